lut_neuron_array_prog: RTL

- Runtime-programmable array of CHANNELS independent LUT neurons.
- Each neuron maps an IN_BITS input to an OUT_BITS output through a 2^IN_BITS-entry truth table held in distributed RAM.
- The table is loaded serially over a config stream; inference then runs through a valid/ready pipeline with a registered output stage.
- Generalises fixed 6-in/1-out ROM neurons so one netlist serves retrained models without regeneration.

---
 rtl/lut_neuron_pkg.sv | 19 +
 rtl/lut_neuron_array_prog_if.sv | 32 +++
 rtl/lut_neuron_ram.sv | 51 +++++
 rtl/lut_neuron_array_prog.sv | 115 +++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the programmable LUT neuron array.
// The load-count width follows the table depth and the channel count.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } lut_state_e;

  function automatic int depth(input int in_bits);
    return 1 << in_bits;
  endfunction

  function automatic int cnt_w(input int channels, input int in_bits);
    return $clog2(channels * depth(in_bits) + 1);
  endfunction

endpackage

// File: rtl/lut_neuron_array_prog_if.sv
// Config, input and output handshakes of the LUT neuron array.
// master drives stimulus, slave is the array itself.
interface lut_neuron_array_prog_if #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int CHANNELS = 4
);

  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [OUT_BITS-1:0]          cfg_data;
  logic                         cfg_last;
  logic                         in_valid;
  logic                         in_ready;
  logic [CHANNELS*IN_BITS-1:0]  in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [CHANNELS*OUT_BITS-1:0] out_data;

  modport master (
    output cfg_valid, cfg_data, cfg_last,
    output in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last,
    input  in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lut_neuron_ram.sv
// One neuron truth table: distributed RAM, one write, one async read.
// LUTNET_INIT_TABLE_EN adds a reset-time copy of INIT into the table.
module lut_neuron_ram
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
`ifdef LUTNET_INIT_TABLE_EN
  ,
  parameter logic [(2**IN_BITS)*OUT_BITS-1:0] INIT = '0
`endif
) (
  input  logic                clk,
`ifdef LUTNET_INIT_TABLE_EN
  input  logic                init,
`endif
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = depth(IN_BITS);

  (* ram_style = "distributed" *)
  logic [OUT_BITS-1:0] mem [DEPTH];

`ifdef LUTNET_INIT_TABLE_EN
  // Reset reloads the ROM image; otherwise serial config writes.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT[i*OUT_BITS +: OUT_BITS];
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  // Serial config writes, one entry per handshake.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_array_prog.sv
// Runtime-programmable array of LUT neurons with serial table load.
// Optional macro LUTNET_INIT_TABLE_EN: reset loads INIT_TABLE, enters RUN.
module lut_neuron_array_prog
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int CHANNELS = 4
`ifdef LUTNET_INIT_TABLE_EN
  ,
  parameter logic [CHANNELS*(2**IN_BITS)*OUT_BITS-1:0] INIT_TABLE = '0
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lut_neuron_array_prog_if.slave bus,
  output logic                   run,
  output logic                   cfg_err
);

  localparam int DEPTH = depth(IN_BITS);
  localparam int TOTAL = CHANNELS * DEPTH;
  localparam int CW    = cnt_w(CHANNELS, IN_BITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

`ifdef LUTNET_INIT_TABLE_EN
  localparam lut_state_e RST_ST = RUN;
`else
  localparam lut_state_e RST_ST = EMPTY;
`endif

  lut_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d, idx, ch_sel;
  logic err_d, cfg_hs, in_hs, final_e;
  logic [CHANNELS*OUT_BITS-1:0] rd;

  assign bus.cfg_ready = 1'b1;
  assign cfg_hs  = bus.cfg_valid;
  assign run     = (state == RUN);
  assign bus.in_ready =
    (state == RUN) && (!bus.out_valid || bus.out_ready);
  assign in_hs   = bus.in_valid && bus.in_ready;
  // A handshake outside LOAD always starts a fresh load at entry 0.
  assign idx     = (state == LOAD) ? cnt : '0;
  assign final_e = (idx == LAST_IDX);
  assign ch_sel  = idx >> IN_BITS;

  // Load sequencing: next state, entry counter and error flag.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    err_d   = cfg_err;
    if (cfg_hs) begin
      state_d = LOAD;
      cnt_d   = idx + CW'(1);
      if (final_e) begin
        state_d = RUN;
        cnt_d   = '0;
        err_d   = !bus.cfg_last;
      end else if (bus.cfg_last) begin
        state_d = EMPTY;
        cnt_d   = '0;
        err_d   = 1'b1;
      end
    end
  end

  // FSM, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RST_ST;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cfg_err <= err_d;
    end
  end

  // Registered output stage with full-throughput handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (in_hs) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= rd;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    lut_neuron_ram #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
`ifdef LUTNET_INIT_TABLE_EN
      ,
      .INIT     (INIT_TABLE[c*DEPTH*OUT_BITS +: DEPTH*OUT_BITS])
`endif
    ) u_ram (
      .clk   (clk),
`ifdef LUTNET_INIT_TABLE_EN
      .init  (!rst_n),
`endif
      .we    (rst_n && cfg_hs && (ch_sel == CW'(c))),
      .waddr (idx[IN_BITS-1:0]),
      .wdata (bus.cfg_data),
      .raddr (bus.in_data[c*IN_BITS +: IN_BITS]),
      .rdata (rd[c*OUT_BITS +: OUT_BITS])
    );
  end

endmodule
